// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: fp32 constants, adder latency
// and elaboration-time helpers used to size the reduction tree.
package conv_pkg;

  localparam int          FP32_WIDTH     = 32;
  localparam logic [31:0] FP_ZERO        = 32'h0000_0000;
  localparam int          FP_ADD_LATENCY = 1;

  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Operand count remaining after lvl pairwise-reduction levels.
  function automatic int level_width(input int n, input int lvl);
    int w = n;
    for (int i = 0; i < lvl; i++) w = (w + 1) / 2;
    return w;
  endfunction

endpackage

// File: rtl/delay_clock.sv
// Fixed-depth data delay line; DEPTH=0 degenerates to a wire.
module delay_clock #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign q = d;
    end else begin : g_shift
      logic [WIDTH-1:0] sr [DEPTH];
      // NOTE: payload stages carry no reset; the owning valid pipeline is reset instead,
      // so stale data here is never observed and the array maps to plain flops/SRLs.
      always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every stage sample the pre-edge value.
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
      assign q = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/fp_top_addsub.sv
// Pipelined fp32 adder: round-to-nearest-even, denormals flushed to zero,
// result delayed by LATENCY cycles.
module FP_Top_AddSub import conv_pkg::*; #(
  parameter int LATENCY = FP_ADD_LATENCY
) (
  input  logic        clk,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  function automatic logic [31:0] fp_add(input logic [31:0] p, input logic [31:0] r);
    logic [31:0] x, y;
    logic [26:0] mx, my, lost;
    logic [27:0] s;
    logic [24:0] m;
    int          ex, ey, d, e;
    if ((p[30:23] == 8'hFF && p[22:0] != 0) || (r[30:23] == 8'hFF && r[22:0] != 0))
      return 32'h7FC0_0000;
    if (p[30:23] == 8'hFF) return (r[30:23] == 8'hFF && p[31] != r[31]) ? 32'h7FC0_0000 : p;
    if (r[30:23] == 8'hFF) return r;
    if (p[30:23] == 8'h00) return (r[30:23] == 8'h00) ? {p[31] & r[31], 31'b0} : r;
    if (r[30:23] == 8'h00) return p;
    // Larger magnitude goes to x so the aligned difference is never negative.
    if (r[30:0] > p[30:0]) begin x = r; y = p; end
    else                   begin x = p; y = r; end
    ex   = {24'b0, x[30:23]};
    ey   = {24'b0, y[30:23]};
    d    = ex - ey;
    mx   = {1'b1, x[22:0], 3'b000};
    my   = {1'b1, y[22:0], 3'b000};
    lost = (d > 26) ? my : (my & ((27'd1 << d) - 27'd1));
    my   = (d > 26) ? 27'd0 : (my >> d);
    my[0] = my[0] | (|lost);
    s = (x[31] == y[31]) ? ({1'b0, mx} + {1'b0, my}) : ({1'b0, mx} - {1'b0, my});
    if (s == 0) return FP_ZERO;
    e = ex;
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 1;
    end else begin
      for (int i = 0; i < 26; i++)
        if (!s[26]) begin
          s = s << 1;
          e = e - 1;
        end
    end
    if (e <= 0) return {x[31], 31'b0};
    m = {1'b0, s[26:3]};
    if (s[2] && (s[1] | s[0] | s[3])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {x[31], 8'hFF, 23'b0};
    return {x[31], e[7:0], m[22:0]};
  endfunction

  logic [31:0] sum_c;
  assign sum_c = fp_add(a, b);

  delay_clock #(.WIDTH(32), .DEPTH(LATENCY)) u_pipe (.clk(clk), .d(sum_c), .q(result));

endmodule

// File: rtl/reduce_tree_level.sv
// One level of the channel adder tree: pairs operands in order and carries an
// odd leftover through a matching delay so every output has the same latency.
module reduce_tree_level import conv_pkg::*; #(
  parameter  int N       = 2,
  parameter  int LATENCY = FP_ADD_LATENCY,
  localparam int M       = (N + 1) / 2
) (
  input  logic                  clk,
  input  logic [FP32_WIDTH*N-1:0] din,
  output logic [FP32_WIDTH*M-1:0] dout
);

  generate
    for (genvar i = 0; i < N / 2; i++) begin : g_pair
      FP_Top_AddSub #(.LATENCY(LATENCY)) u_add (
        .clk    (clk),
        .a      (din[FP32_WIDTH*(2*i)   +: FP32_WIDTH]),
        .b      (din[FP32_WIDTH*(2*i+1) +: FP32_WIDTH]),
        .result (dout[FP32_WIDTH*i      +: FP32_WIDTH])
      );
    end
    if (N % 2 == 1) begin : g_odd
      delay_clock #(.WIDTH(FP32_WIDTH), .DEPTH(LATENCY)) u_pass (
        .clk (clk),
        .d   (din[FP32_WIDTH*(N-1)  +: FP32_WIDTH]),
        .q   (dout[FP32_WIDTH*(M-1) +: FP32_WIDTH])
      );
    end
  endgenerate

endmodule

// File: rtl/conv3d_channel_reduce.sv
// Sums CHANNEL fp32 partial sums through a pipelined adder tree, adds a per-frame
// bias, optionally applies ReLU and counts pixels to flag the end of each frame.
module conv3d_channel_reduce import conv_pkg::*; #(
  parameter int CHANNEL     = 16,
  parameter int IMG_WIDTH   = 56,
  parameter int IMG_HEIGHT  = 56,
  parameter int ADD_LATENCY = FP_ADD_LATENCY
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [CHANNEL-1:0]            lane_valid,
  input  logic [FP32_WIDTH*CHANNEL-1:0] lane_data,
  input  logic [31:0]                   bias_in,
  input  logic                          relu_en,
  output logic [31:0]                   data_out,
  output logic                          valid_out_pixel,
  output logic                          done,
  output logic                          align_err
);

  localparam int LEVELS   = clog2(CHANNEL);
  localparam int FRAME    = IMG_WIDTH * IMG_HEIGHT;
  localparam int CW       = (clog2(FRAME) > 0) ? clog2(FRAME) : 1;
  localparam int BIAS_TAP = LEVELS * ADD_LATENCY;
  localparam int TOTAL    = (LEVELS + 1) * ADD_LATENCY;
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  logic          issue, frame_start, relu_q, relu_eff, relu_t;
  logic [31:0]   bias_q, bias_eff, bias_t, sum;
  logic [CW-1:0] in_cnt, out_cnt;
  logic [TOTAL-1:0] vpipe;
  logic [FP32_WIDTH*CHANNEL-1:0] tree [LEVELS+1];

  assign issue       = lane_valid[0];
  assign frame_start = issue && (in_cnt == '0);
  // The first pixel of a frame uses the live inputs; later pixels reuse the capture.
  assign bias_eff    = frame_start ? bias_in : bias_q;
  assign relu_eff    = frame_start ? relu_en : relu_q;

  assign tree[0] = lane_data;
  generate
    for (genvar lv = 0; lv < LEVELS; lv++) begin : g_level
      localparam int NI = level_width(CHANNEL, lv);
      localparam int NO = level_width(CHANNEL, lv + 1);
      reduce_tree_level #(.N(NI), .LATENCY(ADD_LATENCY)) u_level (
        .clk  (clk),
        .din  (tree[lv][FP32_WIDTH*NI-1:0]),
        .dout (tree[lv+1][FP32_WIDTH*NO-1:0])
      );
      assign tree[lv+1][FP32_WIDTH*CHANNEL-1:FP32_WIDTH*NO] = '0;
    end
  endgenerate

  // Per-pixel frame parameters ride alongside the data so overlapping frames stay separate.
  delay_clock #(.WIDTH(32), .DEPTH(BIAS_TAP)) u_bias_dly (.clk(clk), .d(bias_eff), .q(bias_t));
  delay_clock #(.WIDTH(1),  .DEPTH(TOTAL))    u_relu_dly (.clk(clk), .d(relu_eff), .q(relu_t));

  FP_Top_AddSub #(.LATENCY(ADD_LATENCY)) u_bias_add (
    .clk    (clk),
    .a      (tree[LEVELS][FP32_WIDTH-1:0]),
    .b      (bias_t),
    .result (sum)
  );

  assign done = valid_out_pixel && (out_cnt == LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vpipe           <= '0;
      in_cnt          <= '0;
      out_cnt         <= '0;
      bias_q          <= FP_ZERO;
      relu_q          <= 1'b0;
      align_err       <= 1'b0;
      valid_out_pixel <= 1'b0;
      data_out        <= FP_ZERO;
    end else begin
      vpipe[0] <= issue;
      for (int i = 1; i < TOTAL; i++) vpipe[i] <= vpipe[i-1];

      if (lane_valid != '0 && lane_valid != '1) align_err <= 1'b1;

      if (issue) in_cnt <= (in_cnt == LAST) ? '0 : in_cnt + CW'(1);
      if (frame_start) begin
        bias_q <= bias_in;
        relu_q <= relu_en;
      end

      if (valid_out_pixel) out_cnt <= done ? '0 : out_cnt + CW'(1);

      valid_out_pixel <= vpipe[TOTAL-1];
      // Sign-bit test so -0 and negative NaN are clamped as well.
      if (vpipe[TOTAL-1]) data_out <= (relu_t && sum[31]) ? FP_ZERO : sum;
    end
  end

endmodule

// File: tb/tb_conv3d_channel_reduce.sv
// Scoreboard bench: a 4-lane and a 3-lane reducer on 2x2 frames, directed vectors
// with hand-computed fp32 results, checked by per-instance output monitors.
module tb_conv3d_channel_reduce;

  localparam logic [31:0] ONE  = 32'h3F80_0000;
  localparam logic [31:0] HALF = 32'h3F00_0000;
  localparam logic [31:0] TWO  = 32'h4000_0000;
  localparam logic [31:0] NEG1 = 32'hBF80_0000;
  localparam int          LAT  = 4;

  typedef struct {
    logic [31:0] data;
    logic        done;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [3:0]   lv4;
  logic [127:0] ld4;
  logic [31:0]  bias4, do4;
  logic         relu4, vo4, dn4, ae4;

  logic [2:0]   lv3;
  logic [95:0]  ld3;
  logic [31:0]  bias3, do3;
  logic         relu3, vo3, dn3, ae3;

  conv3d_channel_reduce #(.CHANNEL(4), .IMG_WIDTH(2), .IMG_HEIGHT(2), .ADD_LATENCY(1)) u_dut4 (
    .clk(clk), .resetn(resetn), .lane_valid(lv4), .lane_data(ld4), .bias_in(bias4),
    .relu_en(relu4), .data_out(do4), .valid_out_pixel(vo4), .done(dn4), .align_err(ae4)
  );

  conv3d_channel_reduce #(.CHANNEL(3), .IMG_WIDTH(2), .IMG_HEIGHT(2), .ADD_LATENCY(1)) u_dut3 (
    .clk(clk), .resetn(resetn), .lane_valid(lv3), .lane_data(ld3), .bias_in(bias3),
    .relu_en(relu3), .data_out(do3), .valid_out_pixel(vo3), .done(dn3), .align_err(ae3)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   pos4   = 0;
  int   pos3   = 0;
  exp_t q4[$];
  exp_t q3[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic send4(input logic [3:0] lv, input logic [31:0] lane, input logic [31:0] bias,
                       input logic relu, input logic [31:0] expv);
    @(posedge clk); #1;
    lv4   = lv;
    ld4   = {4{lane}};
    bias4 = bias;
    relu4 = relu;
    q4.push_back('{expv, (pos4 == 3), cyc + LAT});
    pos4 = (pos4 + 1) % 4;
  endtask

  task automatic send3(input logic [31:0] l0, input logic [31:0] l1, input logic [31:0] l2,
                       input logic [31:0] bias, input logic relu, input logic [31:0] expv);
    @(posedge clk); #1;
    lv3   = 3'b111;
    ld3   = {l2, l1, l0};
    bias3 = bias;
    relu3 = relu;
    q3.push_back('{expv, (pos3 == 3), cyc + LAT});
    pos3 = (pos3 + 1) % 4;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      lv4 = '0;
      lv3 = '0;
    end
  endtask

  always @(negedge clk) begin : mon4
    exp_t e;
    if (resetn && vo4) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut4_unexpected: got valid_out_pixel data %h expected no output", do4);
      end else begin
        e = q4.pop_front();
        check("dut4_data",    do4,          e.data);
        check("dut4_done",    {31'b0, dn4}, {31'b0, e.done});
        check("dut4_latency", cyc,          e.cyc);
      end
    end else if (dn4) begin
      checks++; errors++;
      $display("FAIL dut4_done_without_valid: got done 1 expected 0");
    end
  end

  always @(negedge clk) begin : mon3
    exp_t e;
    if (resetn && vo3) begin
      if (q3.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut3_unexpected: got valid_out_pixel data %h expected no output", do3);
      end else begin
        e = q3.pop_front();
        check("dut3_data",    do3,          e.data);
        check("dut3_done",    {31'b0, dn3}, {31'b0, e.done});
        check("dut3_latency", cyc,          e.cyc);
      end
    end else if (dn3) begin
      checks++; errors++;
      $display("FAIL dut3_done_without_valid: got done 1 expected 0");
    end
  end

  initial begin
    resetn = 1'b0;
    lv4 = '0; ld4 = '0; bias4 = '0; relu4 = 1'b0;
    lv3 = '0; ld3 = '0; bias3 = '0; relu3 = 1'b0;
    #1;
    check("rst_data4",  do4,          32'h0);
    check("rst_valid4", {31'b0, vo4}, 32'h0);
    check("rst_done4",  {31'b0, dn4}, 32'h0);
    check("rst_align4", {31'b0, ae4}, 32'h0);
    check("rst_data3",  do3,          32'h0);
    check("rst_valid3", {31'b0, vo3}, 32'h0);
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;

    // Frame A: single 4.5 pixel, then mid-frame bias/relu changes that must be ignored.
    send4(4'hF, ONE, HALF, 1'b0, 32'h4090_0000);
    idle(6);
    for (int i = 0; i < 3; i++) send4(4'hF, NEG1, FP_ZERO_C(), 1'b1, 32'hC060_0000);
    idle(6);

    // Frame B: ReLU sampled on, toggled off mid-frame.
    send4(4'hF, NEG1, 32'h0, 1'b1, 32'h0000_0000);
    send4(4'hF, NEG1, 32'h0, 1'b0, 32'h0000_0000);
    send4(4'hF, ONE,  32'h0, 1'b0, 32'h4080_0000);
    send4(4'hF, NEG1, 32'h0, 1'b0, 32'h0000_0000);
    idle(6);

    // Frames C and D back to back; bias changes after the second pixel.
    for (int i = 0; i < 8; i++)
      send4(4'hF, TWO, (i < 2) ? HALF : ONE, 1'b0, (i < 4) ? 32'h4108_0000 : 32'h4110_0000);
    idle(6);

    // Frame E: one misaligned beat, sticky flag through the rest of the frame.
    check("align_before", {31'b0, ae4}, 32'h0);
    send4(4'h7, ONE, 32'h0, 1'b0, 32'h4080_0000);
    idle(1);
    check("align_rise", {31'b0, ae4}, 32'h1);
    for (int i = 0; i < 3; i++) send4(4'hF, ONE, 32'h0, 1'b0, 32'h4080_0000);
    idle(6);
    check("align_sticky", {31'b0, ae4}, 32'h1);

    // Frame F: three pixels in flight, then asynchronous reset discards them.
    for (int i = 0; i < 3; i++) send4(4'hF, ONE, ONE, 1'b0, 32'h40A0_0000);
    idle(1);
    #2 resetn = 1'b0;
    q4.delete();
    q3.delete();
    pos4 = 0;
    pos3 = 0;
    #1;
    check("async_rst_data",  do4,          32'h0);
    check("async_rst_valid", {31'b0, vo4}, 32'h0);
    check("async_rst_done",  {31'b0, dn4}, 32'h0);
    check("async_rst_align", {31'b0, ae4}, 32'h0);
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
    idle(6);

    // Frame G: bias resampled after reset, done on its own fourth pixel.
    for (int i = 0; i < 4; i++) send4(4'hF, ONE, HALF, 1'b0, 32'h4090_0000);
    idle(2);

    // Three-lane instance: odd-lane passthrough under continuous input.
    send3(ONE,          TWO,          32'h4040_0000, 32'h0, 1'b0, 32'h40C0_0000);
    send3(HALF,         HALF,         ONE,           32'h0, 1'b0, 32'h4000_0000);
    send3(32'h4040_0000, ONE,         32'h4080_0000, 32'h0, 1'b0, 32'h4100_0000);
    send3(TWO,          NEG1,         32'h4100_0000, 32'h0, 1'b0, 32'h4110_0000);
    send3(ONE,          TWO,          32'h4040_0000, ONE,   1'b1, 32'h40E0_0000);
    send3(NEG1,         32'hC000_0000, 32'hC040_0000, ONE,  1'b1, 32'h0000_0000);
    send3(ONE,          ONE,          ONE,           ONE,   1'b1, 32'h4080_0000);
    send3(HALF,         HALF,         ONE,           ONE,   1'b1, 32'h4040_0000);
    idle(10);

    check("pending4", q4.size(), 32'h0);
    check("pending3", q3.size(), 32'h0);
    check("align3_clean", {31'b0, ae3}, 32'h0);
    check("align4_clean", {31'b0, ae4}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic logic [31:0] FP_ZERO_C();
    return 32'h0000_0000;
  endfunction

endmodule

// File: doc/conv3d_channel_reduce.md
Name: conv3d_channel_reduce

Overview:
- Parametrised channel-reduction stage for multi-channel 3x3 convolution.
- Takes CHANNEL per-channel fp32 partial sums, one per conv2d_kernel_size_3 instance, and sums them through a generated pipelined FP adder tree.
- Adds a runtime bias, applies optional ReLU and tracks the output frame.
- Successor to the fixed 16-channel reducer: channel count is arbitrary, including non-power-of-two.

Parameters:
- CHANNEL, 16: number of input lanes, 1..64.
- IMG_WIDTH, 56: output frame width in pixels.
- IMG_HEIGHT, 56: output frame height in pixels.
- ADD_LATENCY, 1: pipeline depth of FP_Top_AddSub in cycles; must match the adder.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- lane_valid  in  CHANNEL  per-lane valid from the conv2d instances
- lane_data  in  32*CHANNEL  fp32 lanes; lane k at bits [32k+31:32k]
- bias_in  in  32  fp32 bias; sampled at frame start
- relu_en  in  1  1 = clamp negative results to +0; sampled at frame start
- data_out  out  32  fp32 result
- valid_out_pixel  out  1  data_out valid, one cycle per pixel
- done  out  1  high with the last pixel of a frame
- align_err  out  1  sticky lane-misalignment flag

Behaviour:
- Reset values: data_out=0, valid_out_pixel=0, done=0, align_err=0, pixel counter=0, bias register=0, relu register=0. All pipeline valids clear.
- Tree issue: a pixel enters the tree when lane_valid[0]=1; all lanes are taken that cycle.
- align_err: set on any cycle where lane_valid is neither all-ones nor all-zeros. Stays set until reset. Data still flows, gated by lane 0.
- Tree shape:
  - LEVELS = clog2(CHANNEL).
  - At each level, operands are paired in order (0+1, 2+3, ...).
  - An odd leftover operand is carried through an ADD_LATENCY-deep register delay so level timing stays aligned.
  - CHANNEL=1 means LEVELS=0: the single lane goes straight to the bias adder.
- Bias stage: one FP_Top_AddSub adds the tree output and bias_q.
- Output register stage: if relu_q=1 and result bit31=1, data_out=32'h0000_0000; otherwise data_out = result. The sign rule applies to -0 and negative NaN as well.
- Latency: input valid to valid_out_pixel = (LEVELS+1)*ADD_LATENCY + 1 cycles. Throughput is one pixel per cycle with no stalls and no backpressure.
- Frame start and sampling:
  - Frame start is the first issued pixel while the issued-pixel count is 0.
  - bias_in and relu_en are captured into bias_q and relu_q on that cycle only.
  - Mid-frame changes do not affect the current frame.
  - The captured pair travels with the frame. A new frame may enter while the previous frame drains, so the sampled values are pipelined with valid.
- Counters:
  - Input-side issued counter: wraps at IMG_WIDTH*IMG_HEIGHT-1 to 0.
  - Output counter: increments on valid_out_pixel.
  - done = valid_out_pixel AND output counter == IMG_WIDTH*IMG_HEIGHT-1. The output counter wraps to 0 on that same edge.
- Back-to-back frames: the last pixel of frame N and the first pixel of frame N+1 may be on consecutive cycles. done pulses exactly once per frame.
- Reset mid-operation: all in-flight pixels are discarded and both counters go to 0. The next valid after reset starts a new frame and resamples bias and relu.

Decomposition:
- Shared package (conv_pkg):
  - FP32_WIDTH=32
  - FP_ZERO=32'h0
  - FP_ADD_LATENCY default
  - clog2 function
- One natural sub-module: reduce_tree_level. It takes N operands and produces ceil(N/2) outputs, using FP_Top_AddSub instances plus a delay_clock for the odd passthrough. The top generates LEVELS instances of it.

Test Plan:
1. CHANNEL=4, all lanes 0x3F800000 (1.0), bias_in 0x3F000000 (0.5), relu_en=0, one pixel -> data_out 0x40900000 (4.5) exactly (2*ADD_LATENCY+ADD_LATENCY+1) cycles later, valid_out_pixel single-cycle.
2. CHANNEL=3, lanes 1.0/2.0/3.0 (0x3F800000/0x40000000/0x40400000), bias 0 -> 0x40C00000 (6.0); checks odd-lane delay alignment under continuous one-per-cycle input with varying values vs. a reference model.
3. CHANNEL=4, lanes 0xBF800000 (-1.0), bias 0: relu_en=1 -> 0x00000000; relu_en=0 -> 0xC0800000. Toggle relu_en mid-frame -> no effect until the next frame.
4. IMG 2x2, two back-to-back frames (8 consecutive valids), bias changed after pixel 2 -> done on output pixels 4 and 8 only; frame 1 uses the old bias, frame 2 the new one.
5. lane_valid=4'b0111 for one cycle -> align_err rises the next cycle and stays 1 through later clean frames, until resetn.
6. Assert resetn low with 3 pixels in flight -> all outputs 0 asynchronously, no valid_out_pixel for discarded pixels; the next frame's done lands on its own 4th pixel.
